mux_arbiter_2to1: RTL and testbench

//   Round-robin arbiter sharing one 2:1 operand mux between two requesters.

---
 rtl/mux_arbiter_2to1_pkg.sv | 10 +
 rtl/mux_arbiter_2to1_if.sv | 36 +++
 rtl/mux_arbiter_2to1_rr_pick2.sv | 29 ++
 rtl/mux_arbiter_2to1.sv | 92 +++++++++
 tb/tb_mux_arbiter_2to1.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_arbiter_2to1_pkg.sv
// Shared types for the 2:1 operand-mux arbiter.
// Optional macro ARB_LOCK_EN enables requester lock.
package mux_arb_pkg;
  localparam int DEF_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/mux_arbiter_2to1_if.sv
// Requester/output bundle for the 2:1 operand-mux arbiter.
// Optional macro ARB_LOCK_EN gives lock0/lock1 meaning.
interface mux_arbiter_2to1_if
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             lock0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             lock1;
  logic             gnt0;
  logic             gnt1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_src;

  modport master (
    output req0, data0, lock0,
    output req1, data1, lock1,
    output out_ready,
    input  gnt0, gnt1,
    input  out_valid, out_data, out_src
  );

  modport slave (
    input  req0, data0, lock0,
    input  req1, data1, lock1,
    input  out_ready,
    output gnt0, gnt1,
    output out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux_arbiter_2to1_rr_pick2.sv
// Two-way round-robin winner select with optional owner mask.
// Lock masking is active only when lock_q is driven high (ARB_LOCK_EN).
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  input  logic lock_q,
  input  logic owner,
  output logic win_vld,
  output logic win
);
  logic r0;
  logic r1;

  // a held lock hides the non-owner
  assign r0 = req0 & ~(lock_q & owner);
  assign r1 = req1 & ~(lock_q & ~owner);

  assign win_vld = r0 | r1;

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (r0 & r1):  win = prio;
      (r1 & ~r0): win = 1'b1;
      default:    win = 1'b0;
    endcase
  end
endmodule

// File: rtl/mux_arbiter_2to1.sv
// Round-robin arbiter feeding one 2:1 operand mux into a valid/ready stage.
// Optional macro ARB_LOCK_EN: winner may hold ownership via lock0/lock1.
module mux_arbiter_2to1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  mux_arbiter_2to1_if.slave bus
);
  state_t           state_q;
  state_t           state_d;
  logic             prio_q;
  logic             lock_q;
  logic             owner_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_w;
  logic             src_q;
  logic             can_load;
  logic             win_vld;
  logic             win;
  logic             load;

  rr_pick2 u_pick (
    .req0    (bus.req0),
    .req1    (bus.req1),
    .prio    (prio_q),
    .lock_q  (lock_q),
    .owner   (owner_q),
    .win_vld (win_vld),
    .win     (win)
  );

  assign can_load = (state_q == IDLE) |
                    ((state_q == BUSY) & bus.out_ready);
  assign load     = rst_n & can_load & win_vld;
  assign data_w   = win ? bus.data1 : bus.data0;

  assign bus.gnt0      = load & ~win;
  assign bus.gnt1      = load & win;
  assign bus.out_valid = (state_q == BUSY);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = BUSY;
    end else if ((state_q == BUSY) && bus.out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      data_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q <= data_w;
        src_q  <= win;
        prio_q <= ~win;
      end
    end
  end

`ifdef ARB_LOCK_EN
  logic lock_w;

  assign lock_w = win ? bus.lock1 : bus.lock0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
    end else if (load) begin
      lock_q  <= lock_w;
      owner_q <= win;
    end
  end
`else
  logic unused_lock;

  assign lock_q      = 1'b0;
  assign owner_q     = 1'b0;
  assign unused_lock = bus.lock0 ^ bus.lock1;
`endif
endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// Directed bench for mux_arbiter_2to1 (optional macro ARB_LOCK_EN).
// Expected values are hand-derived per scenario.
module tb_mux_arbiter_2to1;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mux_arbiter_2to1_if #(.WIDTH(4)) bus ();

  mux_arbiter_2to1 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    bus.req0      = 1'b0;
    bus.req1      = 1'b0;
    bus.lock0     = 1'b0;
    bus.lock1     = 1'b0;
    bus.data0     = 4'h0;
    bus.data1     = 4'h0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n     = 1'b0;
    bus.req0  = 1'b1;
    bus.data0 = 4'hA;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_gnt0 got=%b exp=0", bus.gnt0);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 4'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", bus.out_data);
    end
    bus.req0 = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    bus.req0      = 1'b1;
    bus.data0     = 4'hA;
    #1;
    checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
      failures++;
      $display("FAIL single_gnt got=%b exp=01", {bus.gnt1, bus.gnt0});
    end
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    checks++;
    if ({bus.out_valid, bus.out_src, bus.out_data} !== 6'b1_0_1010) begin
      failures++;
      $display("FAIL single_beat got=v%b s%b d%h exp=v1 s0 dA",
               bus.out_valid, bus.out_src, bus.out_data);
    end
    #1;
    checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b00) begin
      failures++;
      $display("FAIL single_nogrant got=%b exp=00", {bus.gnt1, bus.gnt0});
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_contention();
    logic       w;
    logic [3:0] d;
    do_reset();
    bus.out_ready = 1'b1;
    bus.req0      = 1'b1;
    bus.req1      = 1'b1;
    bus.data0     = 4'h3;
    bus.data1     = 4'hC;
    for (int i = 0; i < 4; i++) begin
      w = (i % 2 == 1);
      d = w ? 4'hC : 4'h3;
      #1;
      checks++;
      if ({bus.gnt1, bus.gnt0} !== {w, ~w}) begin
        failures++;
        $display("FAIL cont_gnt[%0d] got=%b exp=%b", i,
                 {bus.gnt1, bus.gnt0}, {w, ~w});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({bus.out_valid, bus.out_src, bus.out_data} !== {1'b1, w, d}) begin
        failures++;
        $display("FAIL cont_beat[%0d] got=v%b s%b d%h exp=v1 s%b d%h", i,
                 bus.out_valid, bus.out_src, bus.out_data, w, d);
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b1;
    bus.req0      = 1'b1;
    bus.data0     = 4'h5;
    @(posedge clk);
    #1;
    bus.req0      = 1'b0;
    bus.out_ready = 1'b0;
    bus.req1      = 1'b1;
    bus.data1     = 4'h9;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({bus.gnt1, bus.gnt0, bus.out_valid, bus.out_data}
          !== {2'b00, 1'b1, 4'h5}) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=g%b v%b d%h exp=g00 v1 d5", i,
                 {bus.gnt1, bus.gnt0}, bus.out_valid, bus.out_data);
      end
      @(posedge clk);
    end
    #1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b10) begin
      failures++;
      $display("FAIL bp_release got=%b exp=10", {bus.gnt1, bus.gnt0});
    end
    @(posedge clk);
    #1;
    bus.req1 = 1'b0;
    checks++;
    if ({bus.out_valid, bus.out_src, bus.out_data} !== 6'b1_1_1001) begin
      failures++;
      $display("FAIL bp_beat got=v%b s%b d%h exp=v1 s1 d9",
               bus.out_valid, bus.out_src, bus.out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lock();
    logic [4:0] exp;
`ifdef ARB_LOCK_EN
    exp = 5'b10000;
`else
    exp = 5'b01010;
`endif
    do_reset();
    bus.out_ready = 1'b1;
    bus.req0      = 1'b1;
    bus.req1      = 1'b1;
    bus.data0     = 4'h3;
    bus.data1     = 4'hC;
    for (int i = 0; i < 5; i++) begin
      bus.lock0 = (i < 3);
      #1;
      checks++;
      if ({bus.gnt1, bus.gnt0} !== {exp[i], ~exp[i]}) begin
        failures++;
        $display("FAIL lock_gnt[%0d] got=%b exp=%b", i,
                 {bus.gnt1, bus.gnt0}, {exp[i], ~exp[i]});
      end
      @(posedge clk);
      #1;
    end
    clear_inputs();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    bus.req1      = 1'b1;
    bus.data1     = 4'h7;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_loaded got=%b exp=1", bus.out_valid);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.out_src, bus.out_data, bus.gnt1}
        !== 7'b0_0_0000_0) begin
      failures++;
      $display("FAIL mid_reset got=v%b s%b d%h g1%b exp=v0 s0 d0 g10",
               bus.out_valid, bus.out_src, bus.out_data, bus.gnt1);
    end
    clear_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_lock();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
